// File: rtl/enc_dec_pkg.sv
// Shared types and helpers for the 8:3 priority encoder and its one-hot decoder.
package enc_dec_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned OUT_W  = 8;

    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } dec_state_t;

    function automatic logic [OUT_W-1:0] onehot(input code_t code);
        return OUT_W'(1) << code;
    endfunction

endpackage

// File: rtl/onehot_pulse_decoder_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers; dout is valid whenever !empty.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign count   = CNT_W'(wptr_q - rptr_q);
    assign dout    = mem[rptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
        end
    end

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Queues 3-bit codes and replays each as a one-hot word held for HOLD cycles,
// with back-to-back codes switching y directly with no idle gap.
module onehot_pulse_decoder #(
    parameter int unsigned CODE_W = enc_dec_pkg::CODE_W,
    parameter int unsigned OUT_W  = enc_dec_pkg::OUT_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned HOLD   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CODE_W-1:0]          w,
    input  logic                       w_valid,
    output logic                       w_ready,
    output logic [OUT_W-1:0]           y,
    output logic                       z,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    import enc_dec_pkg::dec_state_t;
    import enc_dec_pkg::ST_IDLE;
    import enc_dec_pkg::ST_DRIVE;

    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
    localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    dec_state_t        state_q;
    dec_state_t        state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic [OUT_W-1:0]  y_q;
    logic [OUT_W-1:0]  y_d;
    logic              z_q;
    logic              z_d;
    logic              ready_en_q;

    logic              push_c;
    logic              pop_c;
    logic [CODE_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_count;

    // ready_en_q keeps w_ready low through reset and the edge that ends it
    assign w_ready = ready_en_q && !fifo_full;
    assign push_c  = w_valid && w_ready;
    assign y       = y_q;
    assign z       = z_q;
    assign level   = fifo_count;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (CODE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .pop   (pop_c),
        .din   (w),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_DRIVE;
            ST_DRIVE: if (hold_q == '0 && fifo_empty) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A pop always reloads y and the hold counter in the same edge
    always_comb begin
        pop_c  = 1'b0;
        y_d    = y_q;
        z_d    = z_q;
        hold_d = hold_q;
        case (state_q)
            ST_IDLE: begin
                y_d = '0;
                z_d = 1'b0;
                if (!fifo_empty) begin
                    pop_c  = 1'b1;
                    y_d    = OUT_W'(1) << fifo_dout;
                    z_d    = 1'b1;
                    hold_d = HOLD_W'(HOLD - 1);
                end
            end
            ST_DRIVE: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (!fifo_empty) begin
                    pop_c  = 1'b1;
                    y_d    = OUT_W'(1) << fifo_dout;
                    z_d    = 1'b1;
                    hold_d = HOLD_W'(HOLD - 1);
                end else begin
                    y_d = '0;
                    z_d = 1'b0;
                end
            end
            default: begin
                y_d = '0;
                z_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q        <= '0;
            z_q        <= 1'b0;
            hold_q     <= '0;
            ready_en_q <= 1'b0;
        end else begin
            y_q        <= y_d;
            z_q        <= z_d;
            hold_q     <= hold_d;
            ready_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed bench for onehot_pulse_decoder: vector table plus full, mid-pulse reset and encoder round-trip sequences.
module tb_onehot_pulse_decoder;

    logic       clk;
    logic       reset;
    logic [2:0] w;
    logic       w_valid;
    logic       w_ready;
    logic [7:0] y;
    logic       z;
    logic [2:0] level;

    int n_checks = 0;
    int n_pass   = 0;

    onehot_pulse_decoder #(
        .CODE_W (3),
        .OUT_W  (8),
        .DEPTH  (4),
        .HOLD   (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .w       (w),
        .w_valid (w_valid),
        .w_ready (w_ready),
        .y       (y),
        .z       (z),
        .level   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wv;
        logic [2:0] w;
        logic [7:0] y;
        logic       z;
        logic [2:0] lvl;
        logic       rdy;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic rst, input logic wv, input logic [2:0] wc,
                                input logic [7:0] ey, input logic ez, input logic [2:0] el,
                                input logic er);
        vec_t v;
        v.rst = rst; v.wv = wv; v.w = wc;
        v.y = ey; v.z = ez; v.lvl = el; v.rdy = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Drive one cycle's inputs, then sample just after the rising edge
    task automatic cyc(input logic r, input logic wv, input logic [2:0] wc);
        reset = r; w_valid = wv; w = wc;
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input string name, input logic [7:0] ey, input logic ez,
                      input logic [2:0] el, input logic er);
        chk(name, {20'd0, y, z, level, w_ready}, {20'd0, ey, ez, el, er});
    endtask

    // Reference 8:3 priority encoder: highest set bit wins
    function automatic logic [3:0] enc83(input logic [7:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) c = 3'(i);
        return {|v, c};
    endfunction

    logic [2:0] rt_codes [8];

    initial begin
        reset = 1'b1; w_valid = 1'b0; w = 3'd0;

        // reset, single code, back-to-back 0,7,3
        vecs[0]  = mk(1, 1, 3'd2, 8'h00, 0, 3'd0, 0);
        vecs[1]  = mk(1, 1, 3'd2, 8'h00, 0, 3'd0, 0);
        vecs[2]  = mk(1, 1, 3'd2, 8'h00, 0, 3'd0, 0);
        vecs[3]  = mk(0, 0, 3'd0, 8'h00, 0, 3'd0, 1);
        vecs[4]  = mk(0, 1, 3'd5, 8'h00, 0, 3'd1, 1);
        vecs[5]  = mk(0, 0, 3'd0, 8'h20, 1, 3'd0, 1);
        vecs[6]  = mk(0, 0, 3'd0, 8'h20, 1, 3'd0, 1);
        vecs[7]  = mk(0, 0, 3'd0, 8'h00, 0, 3'd0, 1);
        vecs[8]  = mk(0, 1, 3'd0, 8'h00, 0, 3'd1, 1);
        vecs[9]  = mk(0, 1, 3'd7, 8'h01, 1, 3'd1, 1);
        vecs[10] = mk(0, 1, 3'd3, 8'h01, 1, 3'd2, 1);
        vecs[11] = mk(0, 0, 3'd0, 8'h80, 1, 3'd1, 1);
        vecs[12] = mk(0, 0, 3'd0, 8'h80, 1, 3'd1, 1);
        vecs[13] = mk(0, 0, 3'd0, 8'h08, 1, 3'd0, 1);
        vecs[14] = mk(0, 0, 3'd0, 8'h08, 1, 3'd0, 1);
        vecs[15] = mk(0, 0, 3'd0, 8'h00, 0, 3'd0, 1);
        vecs[16] = mk(0, 0, 3'd0, 8'h00, 0, 3'd0, 1);

        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].rst, vecs[i].wv, vecs[i].w);
            ex($sformatf("vec%0d", i), vecs[i].y, vecs[i].z, vecs[i].lvl, vecs[i].rdy);
        end

        // Fill the FIFO while driving; the code offered when full must be dropped
        cyc(0, 1, 3'd1); ex("full_e0", 8'h00, 0, 3'd1, 1);
        cyc(0, 1, 3'd2); ex("full_e1", 8'h02, 1, 3'd1, 1);
        cyc(0, 1, 3'd3); ex("full_e2", 8'h02, 1, 3'd2, 1);
        cyc(0, 1, 3'd4); ex("full_e3", 8'h04, 1, 3'd2, 1);
        cyc(0, 1, 3'd5); ex("full_e4", 8'h04, 1, 3'd3, 1);
        cyc(0, 1, 3'd6); ex("full_e5", 8'h08, 1, 3'd3, 1);
        cyc(0, 1, 3'd7); ex("full_e6", 8'h08, 1, 3'd4, 0);
        cyc(0, 1, 3'd0); ex("full_drop", 8'h10, 1, 3'd3, 1);
        cyc(0, 0, 3'd0); ex("drain_e8", 8'h10, 1, 3'd3, 1);
        cyc(0, 0, 3'd0); ex("drain_e9", 8'h20, 1, 3'd2, 1);
        cyc(0, 0, 3'd0); ex("drain_e10", 8'h20, 1, 3'd2, 1);
        cyc(0, 0, 3'd0); ex("drain_e11", 8'h40, 1, 3'd1, 1);
        cyc(0, 0, 3'd0); ex("drain_e12", 8'h40, 1, 3'd1, 1);
        cyc(0, 0, 3'd0); ex("drain_e13", 8'h80, 1, 3'd0, 1);
        cyc(0, 0, 3'd0); ex("drain_e14", 8'h80, 1, 3'd0, 1);
        cyc(0, 0, 3'd0); ex("drain_end", 8'h00, 0, 3'd0, 1);
        cyc(0, 0, 3'd0); ex("drain_idle", 8'h00, 0, 3'd0, 1);

        // Reset while driving 6 with two codes queued
        cyc(0, 1, 3'd6); ex("mid_e0", 8'h00, 0, 3'd1, 1);
        cyc(0, 1, 3'd1); ex("mid_e1", 8'h40, 1, 3'd1, 1);
        cyc(0, 1, 3'd2); ex("mid_e2", 8'h40, 1, 3'd2, 1);
        cyc(1, 0, 3'd0); ex("mid_rst", 8'h00, 0, 3'd0, 0);
        cyc(0, 0, 3'd0); ex("mid_rel", 8'h00, 0, 3'd0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 3'd0);
            ex($sformatf("mid_idle%0d", i), 8'h00, 0, 3'd0, 1);
        end

        // Round trip through the reference encoder
        rt_codes[0] = 3'd3; rt_codes[1] = 3'd6; rt_codes[2] = 3'd0; rt_codes[3] = 3'd7;
        rt_codes[4] = 3'd1; rt_codes[5] = 3'd5; rt_codes[6] = 3'd2; rt_codes[7] = 3'd4;
        begin
            int         sent;
            int         got;
            logic       acc;
            logic [7:0] prev_y;
            logic [3:0] e;
            sent = 0; got = 0; prev_y = 8'h00;
            for (int cy = 0; cy < 120; cy++) begin
                if (sent < 8) begin
                    acc = w_ready;
                    cyc(0, 1, rt_codes[sent]);
                end else begin
                    acc = 1'b0;
                    cyc(0, 0, 3'd0);
                end
                if (acc) sent++;
                e = enc83(y);
                if (z || e[3]) chk($sformatf("rt_valid_c%0d", cy), {31'd0, e[3]}, {31'd0, z});
                if (z && y != prev_y) begin
                    if (got < 8) chk($sformatf("rt_code%0d", got), {29'd0, e[2:0]}, {29'd0, rt_codes[got]});
                    got++;
                end
                prev_y = y;
                if (sent == 8 && got >= 8 && !z) break;
            end
            chk("rt_count", 32'(got), 32'd8);
            ex("rt_idle", 8'h00, 0, 3'd0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
